// File: rtl/priority_scanner.sv
// ---------------------------------------------------------------------------
// priority_scanner
//
// Registered priority encoder.  A WIDTH-bit request word is captured and
// then every set bit is reported as an index, one index per output
// handshake.  The order is highest set bit first (MSB_FIRST=1) or lowest
// set bit first (MSB_FIRST=0).
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid && ready are both 1.  A producer that raises valid holds it
// and its payload stable until that transfer.  in_ready depends on the FSM
// state only.  out_valid/ub/last/remain depend on registered state only.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   in_valid      num is valid
//   in_ready      block can accept a word (IDLE)
//   num           request word
//   out_valid     ub/last/remain are valid (SCAN)
//   out_ready     consumer takes the current index
//   ub            index of the current highest-priority pending bit
//   last          ub is the final pending bit of the word
//   remain        pending bits including the current one
//   o_dbg_state   FSM state, 0 = IDLE, 1 = SCAN
//   o_dbg_pend    pending-bit mask
//   o_dbg_cnt     pending-bit count
// ---------------------------------------------------------------------------
module priority_scanner #(
   parameter int WIDTH     = 8,
   parameter int IDX_W     = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] num,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] ub,
   output logic             last,
   output logic [IDX_W:0]   remain,
   output logic             o_dbg_state,
   output logic [WIDTH-1:0] o_dbg_pend,
   output logic [IDX_W:0]   o_dbg_cnt
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pend;
   logic [WIDTH-1:0] w_pend_nxt;
   logic [IDX_W:0]   r_cnt;
   logic [IDX_W:0]   w_cnt_nxt;
   logic [IDX_W-1:0] w_ub;
   logic [IDX_W:0]   w_num_cnt;

   // Population count of the incoming word; loaded into r_cnt on accept so
   // that r_cnt always equals popcount(r_pend).
   always_comb begin
      w_num_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_num_cnt = w_num_cnt + {{IDX_W{1'b0}}, num[i]};
      end
   end

   // Priority encode the pending mask.  The later assignment in the loop
   // wins, so the loop direction selects which end of the word has priority.
   always_comb begin
      w_ub = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r_pend[i]) w_ub = IDX_W'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pend[i]) w_ub = IDX_W'(i);
         end
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_cnt_nxt   = r_cnt;
      in_ready    = (r_state == S_IDLE);
      out_valid   = (r_state == S_SCAN);

      case (r_state)
         S_IDLE: begin
            // A zero word is consumed by the handshake and simply dropped.
            if (in_valid && (num != '0)) begin
               w_pend_nxt  = num;
               w_cnt_nxt   = w_num_cnt;
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (out_ready) begin
               w_pend_nxt = r_pend & ~({{(WIDTH-1){1'b0}}, 1'b1} << w_ub);
               w_cnt_nxt  = r_cnt - 1'b1;
               if (r_cnt == 1) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // In IDLE pend and cnt are zero, so ub, last and remain read as zero.
   assign ub          = w_ub;
   assign last        = (r_cnt == 1);
   assign remain      = r_cnt;
   assign o_dbg_state = r_state;
   assign o_dbg_pend  = r_pend;
   assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_priority_scanner.sv
// ---------------------------------------------------------------------------
// tb_priority_scanner
//
// Three instances share clock and reset:
//   id 0: WIDTH=8,  MSB_FIRST=1
//   id 1: WIDTH=8,  MSB_FIRST=0
//   id 2: WIDTH=16, MSB_FIRST=1
// The reference model turns a word into the ordered list of its set-bit
// indices (exp_q); each output beat must match the head of that list.
// ---------------------------------------------------------------------------
module tb_priority_scanner;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid  [3];
   logic        out_ready [3];
   logic [15:0] num_v     [3];

   logic        in_ready_w  [3];
   logic        out_valid_w [3];
   logic        last_w      [3];
   logic        state_w     [3];
   logic [3:0]  ub_w        [3];
   logic [4:0]  remain_w    [3];
   logic [4:0]  cnt_w       [3];
   logic [15:0] pend_w      [3];

   logic [2:0]  ub_a, ub_b;
   logic [3:0]  ub_c;
   logic [3:0]  remain_a, remain_b, cnt_a, cnt_b;
   logic [4:0]  remain_c, cnt_c;
   logic [7:0]  pend_a, pend_b;
   logic [15:0] pend_c;

   priority_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready_w[0]), .num(num_v[0][7:0]),
      .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
      .ub(ub_a), .last(last_w[0]), .remain(remain_a),
      .o_dbg_state(state_w[0]), .o_dbg_pend(pend_a), .o_dbg_cnt(cnt_a)
   );

   priority_scanner #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready_w[1]), .num(num_v[1][7:0]),
      .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
      .ub(ub_b), .last(last_w[1]), .remain(remain_b),
      .o_dbg_state(state_w[1]), .o_dbg_pend(pend_b), .o_dbg_cnt(cnt_b)
   );

   priority_scanner #(.WIDTH(16), .MSB_FIRST(1'b1)) u_c (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready_w[2]), .num(num_v[2]),
      .out_valid(out_valid_w[2]), .out_ready(out_ready[2]),
      .ub(ub_c), .last(last_w[2]), .remain(remain_c),
      .o_dbg_state(state_w[2]), .o_dbg_pend(pend_c), .o_dbg_cnt(cnt_c)
   );

   assign ub_w[0]     = {1'b0, ub_a};
   assign ub_w[1]     = {1'b0, ub_b};
   assign ub_w[2]     = ub_c;
   assign remain_w[0] = {1'b0, remain_a};
   assign remain_w[1] = {1'b0, remain_b};
   assign remain_w[2] = remain_c;
   assign cnt_w[0]    = {1'b0, cnt_a};
   assign cnt_w[1]    = {1'b0, cnt_b};
   assign cnt_w[2]    = cnt_c;
   assign pend_w[0]   = {8'h00, pend_a};
   assign pend_w[1]   = {8'h00, pend_b};
   assign pend_w[2]   = pend_c;

   int width_of [3] = '{8, 8, 16};
   bit msb_of   [3] = '{1'b1, 1'b0, 1'b1};

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];
   bit         inv_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: ordered list of set-bit indices for a word.
   task automatic build_exp(input int id, input logic [15:0] w);
      exp_q.delete();
      for (int k = 0; k < width_of[id]; k++) begin
         int b;
         b = msb_of[id] ? (width_of[id] - 1 - k) : k;
         if (w[b]) exp_q.push_back(4'(b));
      end
   endtask

   // Structural invariants, sampled on the falling edge.
   always @(negedge clk) begin
      if (inv_en) begin
         for (int d = 0; d < 3; d++) begin
            chk("cnt_popcount", int'(cnt_w[d]), $countones(pend_w[d]));
            if (state_w[d]) chk("scan_cnt_nonzero", int'(cnt_w[d] != 0), 1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input int id, input logic [15:0] w);
      chk("in_ready_before_send", int'(in_ready_w[id]), 1);
      in_valid[id] = 1'b1;
      num_v[id]    = w;
      @(posedge clk); #1;
      in_valid[id] = 1'b0;
      num_v[id]    = 16'($urandom);
   endtask

   // Drain one word.  stall_beat/stall_len hold out_ready low for stall_len
   // cycles while beat stall_beat is presented; rnd picks out_ready randomly.
   task automatic drain(input int id, input logic [15:0] w, input int stall_beat,
                        input int stall_len, input bit rnd, input int exp_first,
                        input int exp_cnt);
      int beat, stalled, cyc;
      bit rdy;
      build_exp(id, w);
      if (exp_first >= 0) chk("tbl_remain_first", int'(remain_w[id]), exp_cnt);
      if (exp_first >= 0 && exp_q.size() > 0) chk("tbl_ub_first", int'(ub_w[id]), exp_first);
      beat = 0; stalled = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
         chk("out_valid_scan", int'(out_valid_w[id]), 1);
         chk("in_ready_scan",  int'(in_ready_w[id]), 0);
         chk("ub",             int'(ub_w[id]), int'(exp_q[0]));
         chk("remain",         int'(remain_w[id]), exp_q.size());
         chk("last",           int'(last_w[id]), int'(exp_q.size() == 1));
         if (rnd) rdy = ($urandom_range(0, 3) != 0);
         else     rdy = !(beat == stall_beat && stalled < stall_len);
         out_ready[id] = rdy;
         @(posedge clk); #1;
         if (rdy) begin
            void'(exp_q.pop_front());
            beat++;
         end else begin
            stalled++;
         end
         cyc++;
      end
      if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
      out_ready[id] = 1'b1;
      chk("out_valid_idle", int'(out_valid_w[id]), 0);
      chk("in_ready_idle",  int'(in_ready_w[id]), 1);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int          id;
      logic [15:0] w;
      int          stall_beat;
      int          stall_len;
      int          exp_first;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 16'h004C, -1, 0,  6, 3};
      tbl[1] = '{1, 16'h004C, -1, 0,  2, 3};
      tbl[2] = '{1, 16'h0001, -1, 0,  0, 1};
      tbl[3] = '{0, 16'h000B,  0, 3,  3, 3};
      tbl[4] = '{0, 16'h0000, -1, 0,  0, 0};
      tbl[5] = '{0, 16'h00FF, -1, 0,  7, 8};
      tbl[6] = '{2, 16'h8001, -1, 0, 15, 2};
      tbl[7] = '{1, 16'h000B,  1, 2,  0, 3};

      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b1;
         num_v[d]     = '0;
      end

      // Clock/reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      inv_en = 1'b1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_in_ready",  int'(in_ready_w[d]), 1);
         chk("rst_out_valid", int'(out_valid_w[d]), 0);
         chk("rst_ub",        int'(ub_w[d]), 0);
         chk("rst_last",      int'(last_w[d]), 0);
         chk("rst_remain",    int'(remain_w[d]), 0);
      end

      // Table: the zero word (entry 4) is followed at once by 8'hFF.
      for (int t = 0; t < 8; t++) begin
         send_word(tbl[t].id, tbl[t].w);
         drain(tbl[t].id, tbl[t].w, tbl[t].stall_beat, tbl[t].stall_len,
               1'b0, tbl[t].exp_first, tbl[t].exp_cnt);
      end

      // Reset while ub=3 of 8'b01001100 is presented, with out_ready high.
      send_word(0, 16'h004C);
      chk("rst_seq_ub6", int'(ub_w[0]), 6);
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      chk("rst_seq_ub3", int'(ub_w[0]), 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_scan_out_valid", int'(out_valid_w[0]), 0);
      chk("rst_scan_in_ready",  int'(in_ready_w[0]), 1);
      chk("rst_scan_remain",    int'(remain_w[0]), 0);
      chk("rst_scan_last",      int'(last_w[0]), 0);
      send_word(0, 16'h004C);
      drain(0, 16'h004C, -1, 0, 1'b0, 6, 3);

      // Randomised words with random consumer back-pressure.
      for (int r = 0; r < 40; r++) begin
         int          id;
         logic [15:0] w;
         id = $urandom_range(0, 2);
         w  = 16'($urandom);
         if (width_of[id] == 8) w = w & 16'h00FF;
         if ($urandom_range(0, 7) == 0) w = '0;
         send_word(id, w);
         drain(id, w, -1, 0, 1'b1, -1, 0);
      end

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/priority_scanner.md
# priority_scanner

Parametrised, registered priority encoder that accepts a WIDTH-bit request word and emits the index of every set bit, one index per handshake, in priority order. Supersedes the single-shot combinational encoder: it adds a selectable scan direction, valid/ready flow control on both sides, a last-index flag and a remaining-bit count. It sits between request sources and any consumer that services requests one at a time, such as an interrupt dispatcher or a scheduler.

## Interface
- WIDTH, 8, request word width; must be ≥ 2.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.
- MSB_FIRST, 1, 1 = highest set bit first (classic priority order), 0 = lowest set bit first.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  num is valid.
- in_ready  output  1  block can accept a word.
- num  input  WIDTH  request word.
- out_valid  output  1  ub, last and remain are valid.
- out_ready  input  1  consumer takes the current index.
- ub  output  IDX_W  index of the current highest-priority pending bit.
- last  output  1  ub is the final pending bit of the word.
- remain  output  IDX_W+1  number of pending bits, including the current one.

## Operation
- State is a pending mask `pend[WIDTH-1:0]`, a count `cnt[IDX_W:0]` and a two-state FSM (IDLE, SCAN).
- Reset (rst=1 at a clock edge):
  - pend=0, cnt=0, state=IDLE.
  - Next cycle: in_ready=1, out_valid=0, ub=0, last=0, remain=0.
- IDLE:
  - in_ready=1 and out_valid=0.
  - Accept occurs when in_valid && in_ready.
  - Accept with num≠0: pend←num, cnt←popcount(num), state←SCAN.
  - Accept with num=0: the word is consumed and dropped; state stays IDLE and no output is produced.
- SCAN:
  - in_ready=0 and out_valid=1.
  - ub = index of the highest set bit of pend if MSB_FIRST=1, else the lowest set bit. ub is combinational from registered state only, with no path from inputs.
  - last = (cnt==1). remain = cnt.
  - On out_valid && out_ready: clear bit ub in pend and decrement cnt.
  - If last was 1 at that handshake, state←IDLE.
- Stall: while out_ready=0, ub, last and remain hold stable and out_valid stays 1.
- No new word is accepted until the current word is fully drained. in_ready depends on state only and never on out_ready.
- Reset during SCAN: the in-flight word is discarded with no further outputs. Reset takes priority over any same-cycle handshake.
- Invariant: cnt == popcount(pend) at all times. In SCAN, cnt ≥ 1.

## Timing
- Input word accepted at edge N -> out_valid=1 from cycle N+1 with the first index.
- Zero-stall drain: a word with k set bits occupies cycles N+1..N+k, and in_ready returns to 1 in cycle N+k+1.
- Back-to-back throughput: one word per k+1 cycles.
- Zero-word accept: in_ready stays 1, so the next word can be accepted at the following edge.
- Output stable from edge to edge; ub changes only after a handshake edge.
- remain width IDX_W+1 covers the all-ones word (remain=WIDTH).

## Test plan
- WIDTH=8, MSB_FIRST=1, num=8'b01001100, out_ready=1 -> ub=6,3,2 on cycles N+1..N+3; remain=3,2,1; last=1 only with ub=2; in_ready=1 at N+4.
- Same word with MSB_FIRST=0 -> ub=2,3,6; last with ub=6. Then num=8'b00000001 -> a single output ub=0, last=1, remain=1.
- num=8'b00001011 with out_ready low for 3 cycles after the first beat -> ub=3 held for 4 cycles, then 1,0. No index is duplicated or skipped, and in_ready stays 0 throughout.
- num=8'h00 accepted -> out_valid never rises and in_ready stays 1. Next word num=8'hFF -> remain=8 and ub=7 down to 0.
- Reset asserted while SCAN holds ub=3 of 8'b01001100 -> next cycle out_valid=0, in_ready=1, remain=0. A fresh word then starts from its own highest bit.
- WIDTH=16 (IDX_W=4), MSB_FIRST=1, num=16'h8001 -> ub=15 then 0; remain=2,1. Check that cnt==popcount(pend) every cycle.
